qspi_req_arb: RTL and testbench
===============================

# qspi_req_arb

Round-robin arbiter and transaction sequencer for the qspi_wrap byte-register port. It lets NREQ independent requesters share one qspi_wrap request/response channel, such as the AXI bridge, a boot loader or a flash-status poller. It keeps exactly one transaction in flight, routes each response back to the requester that issued it, and converts a missing response into an error response after a timeout. It sits between the requesters and the qspi_wrap instance, in parallel with the spi_flash path.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- TMO_CYC, 4096, cycles in WAIT before a timeout response is generated (≥2).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_vld  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  per-requester accept; at most one bit high.
- req_addr  in  4*NREQ  register address, slice i = [4i+3:4i].
- req_read  in  NREQ  1 = read, 0 = write.
- req_dat  in  8*NREQ  write data, slice i = [8i+7:8i].
- rsp_vld  out  NREQ  response valid to the owner only.
- rsp_rdy  in  NREQ  per-requester response ready.
- rsp_dat  out  8  response data (shared).
- rsp_err  out  1  1 = timeout response, rsp_dat = 0.
- flash_busy  in  1  spi_flash busy; blocks new grants.
- m_req_vld / m_req_rdy  out / in  1 / 1  qspi_wrap request handshake.
- m_req_addr, m_req_read, m_req_dat  out  4, 1, 8  latched request fields.
- m_rsp_vld / m_rsp_rdy  in / out  1 / 1  qspi_wrap response handshake.
- m_rsp_dat  in  8  response data from qspi_wrap.
- grant  out  NREQ  one-hot owner; 0 in IDLE.
- stray_err  out  1  sticky; a response arrived in IDLE. Cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Encode in a registered FSM.
- **IDLE**
  - m_rsp_rdy=1.
  - If |req_vld and ~flash_busy, select the winner by round-robin. Search starts at (last+1) mod NREQ and wraps.
  - Drive req_rdy[winner]=1 combinationally in that cycle.
  - Latch the winner index, addr, read and dat.
  - Next state is ISSUE.
  - If m_rsp_vld is high, drop the beat and set stray_err.
- **ISSUE**
  - m_req_vld=1 with the latched fields, held stable until m_req_rdy.
  - On m_req_vld & m_req_rdy, go to WAIT and clear the timeout counter.
  - No timeout in ISSUE.
  - m_rsp_rdy=0.
- **WAIT**
  - m_rsp_rdy=1. The counter increments each cycle.
  - On m_rsp_vld, latch m_rsp_dat, set err=0 and go to RESP.
  - Otherwise, when counter == TMO_CYC-1, latch dat=0, set err=1 and go to RESP.
  - If m_rsp_vld and the timeout condition occur in the same cycle, the response wins (err=0).
- **RESP**
  - rsp_vld[owner]=1 with rsp_dat and rsp_err.
  - On rsp_rdy[owner], set last=owner and go to IDLE.
  - m_rsp_rdy=0.
- Reads and writes are sequenced identically; both receive one response.
- grant = one-hot(owner) in ISSUE/WAIT/RESP and 0 in IDLE.
- flash_busy is sampled only in IDLE. It does not abort a transaction already granted.
- Requests from non-winners are not accepted; their req_vld is simply held.

## Timing
- Reset (async assert) state:
  - FSM = IDLE, last = NREQ-1 (requester 0 has first priority).
  - All req_rdy, rsp_vld, m_req_vld = 0.
  - m_req_addr/read/dat = 0, rsp_dat = 0, rsp_err = 0, grant = 0, stray_err = 0, counter = 0.
- In IDLE, m_rsp_rdy = 1 combinationally.
- Reset asserted mid-transaction returns to IDLE immediately. Any in-flight qspi_wrap response is then treated as stray.
- Minimum transaction with zero-wait slave and requester:
  - accept at T;
  - m_req_vld at T+1;
  - WAIT at T+2, m_rsp_vld sampled at T+2;
  - rsp_vld at T+3;
  - IDLE at T+4, when the next accept can occur.
- Back-to-back throughput is therefore one transaction per 4 cycles.
- Timeout: with no m_rsp_vld, rsp_vld rises TMO_CYC cycles after the m_req handshake cycle.
- All outputs except req_rdy and m_rsp_rdy are registered. req_rdy is combinational from req_vld, flash_busy, FSM state and last.

## Test plan
- Reset, then req_vld[0] with addr=4'h3, read=1 and slave response 8'hA5 → req_rdy[0] at T, m_req_addr=3 at T+1, rsp_vld[0] at T+3 with rsp_dat=8'hA5, rsp_err=0.
- Requesters 0..3 held valid continuously (writes, dat=8'h10+i) → grant order 0,1,2,3,0, each 4 cycles apart, m_req_dat matching the winner.
- flash_busy=1 with req_vld[2]=1 for 10 cycles → req_rdy stays 0 and m_req_vld stays 0. Drop busy → accept on the same cycle.
- Slave never responds with TMO_CYC=8 → rsp_vld[owner] exactly 8 cycles after the m_req handshake, rsp_err=1, rsp_dat=0. A later m_rsp_vld in IDLE sets stray_err=1.
- m_req_rdy held low for 5 cycles, then rsp_rdy[1] held low for 3 cycles → m_req fields stable throughout and rsp_vld/rsp_dat stable until accepted. No other requester is granted.
- Assert rst while in WAIT → all outputs return to reset values immediately. The next grant goes to requester 0.

Source files
------------

// File: rtl/qspi_req_arb.sv
// Round-robin arbiter that shares one qspi_wrap byte-register channel among NREQ requesters,
// keeping one transaction in flight and turning a missing response into a timeout error.
module qspi_req_arb #(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_vld,
    output logic [NREQ-1:0]     req_rdy,
    input  logic [4*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]     req_read,
    input  logic [8*NREQ-1:0]   req_dat,
    output logic [NREQ-1:0]     rsp_vld,
    input  logic [NREQ-1:0]     rsp_rdy,
    output logic [7:0]          rsp_dat,
    output logic                rsp_err,
    input  logic                flash_busy,
    output logic                m_req_vld,
    input  logic                m_req_rdy,
    output logic [3:0]          m_req_addr,
    output logic                m_req_read,
    output logic [7:0]          m_req_dat,
    input  logic                m_rsp_vld,
    output logic                m_rsp_rdy,
    input  logic [7:0]          m_rsp_dat,
    output logic [NREQ-1:0]     grant,
    output logic                stray_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef logic [IW:0] sum_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     last_reg, owner_reg, winner;
    logic              win_vld, accept, timeout;
    sum_t              idx_sum;
    logic [CW-1:0]     cnt_reg, cnt_inc;
    logic [NREQ-1:0]   rsp_vld_reg, grant_reg;
    logic [7:0]        rsp_dat_reg, m_req_dat_reg;
    logic              rsp_err_reg, m_req_vld_reg, m_req_read_reg, stray_err_reg;
    logic [3:0]        m_req_addr_reg;

    logic [3:0]        addr_arr [NREQ];
    logic [7:0]        dat_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[4*gi +: 4];
            assign dat_arr[gi]  = req_dat[8*gi +: 8];
            assign req_rdy[gi]  = accept && !rst && (winner == IW'(gi));
        end
    endgenerate

    // Round-robin search: first valid requester after the last owner, wrapping.
    always_comb begin
        win_vld = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_sum = {1'b0, last_reg} + sum_t'(k);
            if (idx_sum >= sum_t'(NREQ)) begin
                idx_sum = idx_sum - sum_t'(NREQ);
            end
            if (!win_vld && req_vld[idx_sum[IW-1:0]]) begin
                win_vld = 1'b1;
                winner  = idx_sum[IW-1:0];
            end
        end
    end

    assign accept    = (state_reg == S_IDLE) && win_vld && !flash_busy;
    assign m_rsp_rdy = (state_reg == S_IDLE) || (state_reg == S_WAIT);
    // The increment counts the current WAIT cycle, so rsp_vld rises TMO_CYC cycles after the handshake.
    assign cnt_inc   = cnt_reg + CW'(1);
    assign timeout   = (cnt_inc == TMO_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_ISSUE;
            S_ISSUE: if (m_req_rdy) state_next = S_WAIT;
            S_WAIT:  if (m_rsp_vld || timeout) state_next = S_RESP;
            S_RESP:  if (|(rsp_rdy & grant_reg)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg       <= IW'(NREQ - 1);
            owner_reg      <= '0;
            cnt_reg        <= '0;
            rsp_vld_reg    <= '0;
            grant_reg      <= '0;
            rsp_dat_reg    <= '0;
            rsp_err_reg    <= 1'b0;
            m_req_vld_reg  <= 1'b0;
            m_req_addr_reg <= '0;
            m_req_read_reg <= 1'b0;
            m_req_dat_reg  <= '0;
            stray_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (m_rsp_vld) begin
                        stray_err_reg <= 1'b1;
                    end
                    if (accept) begin
                        owner_reg      <= winner;
                        grant_reg      <= NREQ'(1) << winner;
                        m_req_vld_reg  <= 1'b1;
                        m_req_addr_reg <= addr_arr[winner];
                        m_req_read_reg <= req_read[winner];
                        m_req_dat_reg  <= dat_arr[winner];
                    end
                end
                S_ISSUE: begin
                    if (m_req_rdy) begin
                        m_req_vld_reg <= 1'b0;
                        cnt_reg       <= '0;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_inc;
                    // A response arriving on the timeout cycle takes precedence.
                    if (m_rsp_vld) begin
                        rsp_dat_reg <= m_rsp_dat;
                        rsp_err_reg <= 1'b0;
                        rsp_vld_reg <= grant_reg;
                    end else if (timeout) begin
                        rsp_dat_reg <= '0;
                        rsp_err_reg <= 1'b1;
                        rsp_vld_reg <= grant_reg;
                    end
                end
                S_RESP: begin
                    if (|(rsp_rdy & grant_reg)) begin
                        rsp_vld_reg <= '0;
                        grant_reg   <= '0;
                        last_reg    <= owner_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_vld    = rsp_vld_reg;
    assign rsp_dat    = rsp_dat_reg;
    assign rsp_err    = rsp_err_reg;
    assign grant      = grant_reg;
    assign m_req_vld  = m_req_vld_reg;
    assign m_req_addr = m_req_addr_reg;
    assign m_req_read = m_req_read_reg;
    assign m_req_dat  = m_req_dat_reg;
    assign stray_err  = stray_err_reg;

endmodule

// File: tb/tb_qspi_req_arb.sv
// Directed bench for qspi_req_arb: arbitration order, flash_busy gating, timeout,
// stalls on both handshakes, stray responses and reset in the middle of a transaction.
module tb_qspi_req_arb;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_vld = '0;
    logic [NREQ-1:0]   req_rdy;
    logic [4*NREQ-1:0] req_addr = '0;
    logic [NREQ-1:0]   req_read = '0;
    logic [8*NREQ-1:0] req_dat = '0;
    logic [NREQ-1:0]   rsp_vld;
    logic [NREQ-1:0]   rsp_rdy = '1;
    logic [7:0]        rsp_dat;
    logic              rsp_err;
    logic              flash_busy = 1'b0;
    logic              m_req_vld;
    logic              m_req_rdy = 1'b1;
    logic [3:0]        m_req_addr;
    logic              m_req_read;
    logic [7:0]        m_req_dat;
    logic              m_rsp_vld = 1'b0;
    logic              m_rsp_rdy;
    logic [7:0]        m_rsp_dat = '0;
    logic [NREQ-1:0]   grant;
    logic              stray_err;

    int checks = 0;
    int errors = 0;

    qspi_req_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_read(req_read), .req_dat(req_dat),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .flash_busy(flash_busy),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr), .m_req_read(m_req_read),
        .m_req_dat(m_req_dat), .m_rsp_vld(m_rsp_vld), .m_rsp_rdy(m_rsp_rdy), .m_rsp_dat(m_rsp_dat),
        .grant(grant), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL reset_grant got %h exp 0", grant); end
        checks++; if (req_rdy !== 4'h0) begin errors++; $display("FAIL reset_req_rdy got %h exp 0", req_rdy); end
        checks++; if (rsp_vld !== 4'h0) begin errors++; $display("FAIL reset_rsp_vld got %h exp 0", rsp_vld); end
        checks++; if ({m_req_vld, m_req_addr, m_req_read, m_req_dat} !== 14'h0) begin
            errors++; $display("FAIL reset_m_req got %b/%h/%b/%h exp all 0", m_req_vld, m_req_addr, m_req_read, m_req_dat);
        end
        checks++; if ({rsp_dat, rsp_err, stray_err} !== 10'h0) begin
            errors++; $display("FAIL reset_rsp got %h/%b/%b exp 0/0/0", rsp_dat, rsp_err, stray_err);
        end
        checks++; if (m_rsp_rdy !== 1'b1) begin errors++; $display("FAIL reset_m_rsp_rdy got %b exp 1", m_rsp_rdy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_read;
        req_addr[3:0] = 4'h3;
        req_read[0]   = 1'b1;
        req_vld       = 4'b0001;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL basic_accept req_rdy got %b exp 0001", req_rdy); end
        tick();
        req_vld = '0;
        checks++; if (m_req_vld !== 1'b1 || m_req_addr !== 4'h3 || m_req_read !== 1'b1) begin
            errors++; $display("FAIL basic_issue got vld=%b addr=%h rd=%b exp 1/3/1", m_req_vld, m_req_addr, m_req_read);
        end
        checks++; if (m_rsp_rdy !== 1'b0) begin errors++; $display("FAIL basic_issue_m_rsp_rdy got %b exp 0", m_rsp_rdy); end
        tick();
        checks++; if (m_req_vld !== 1'b0 || m_rsp_rdy !== 1'b1) begin
            errors++; $display("FAIL basic_wait got m_req_vld=%b m_rsp_rdy=%b exp 0/1", m_req_vld, m_rsp_rdy);
        end
        m_rsp_vld = 1'b1;
        m_rsp_dat = 8'hA5;
        tick();
        m_rsp_vld = 1'b0;
        checks++; if (rsp_vld !== 4'b0001 || rsp_dat !== 8'hA5 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL basic_resp got vld=%b dat=%h err=%b exp 0001/a5/0", rsp_vld, rsp_dat, rsp_err);
        end
        tick();
        checks++; if (rsp_vld !== 4'h0 || grant !== 4'h0) begin
            errors++; $display("FAIL basic_idle got rsp_vld=%b grant=%b exp 0/0", rsp_vld, grant);
        end
        $display("txn basic: req0 read addr=3 rsp=%h", 8'hA5);
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_dat  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_read = '0;
        req_vld  = 4'hF;
        #1;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % 4);
            exp_d = 8'h10 + 8'(n % 4);
            checks++; if (req_rdy !== exp_g) begin errors++; $display("FAIL rr_accept[%0d] got %b exp %b", n, req_rdy, exp_g); end
            tick();
            checks++; if (grant !== exp_g || m_req_vld !== 1'b1 || m_req_dat !== exp_d || m_req_read !== 1'b0) begin
                errors++; $display("FAIL rr_issue[%0d] got g=%b vld=%b dat=%h rd=%b exp %b/1/%h/0", n, grant, m_req_vld, m_req_dat, m_req_read, exp_g, exp_d);
            end
            tick();
            m_rsp_vld = 1'b1;
            m_rsp_dat = 8'h80 + 8'(n);
            tick();
            m_rsp_vld = 1'b0;
            checks++; if (rsp_vld !== exp_g || rsp_dat !== 8'h80 + 8'(n)) begin
                errors++; $display("FAIL rr_resp[%0d] got vld=%b dat=%h exp %b/%h", n, rsp_vld, rsp_dat, exp_g, 8'h80 + 8'(n));
            end
            $display("txn rr[%0d]: grant=%b wdat=%h", n, exp_g, exp_d);
            tick();
        end
        req_vld = '0;
    endtask

    task automatic test_flash_busy;
        flash_busy = 1'b1;
        req_vld    = 4'b0100;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (req_rdy !== 4'h0 || m_req_vld !== 1'b0) begin
                errors++; $display("FAIL busy_block[%0d] got rdy=%b m_req_vld=%b exp 0/0", i, req_rdy, m_req_vld);
            end
            tick();
        end
        flash_busy = 1'b0;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL busy_release got %b exp 0100", req_rdy); end
        tick();
        req_vld = '0;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL busy_grant got %b exp 0100", grant); end
        tick();
        m_rsp_vld = 1'b1;
        m_rsp_dat = 8'h42;
        tick();
        m_rsp_vld = 1'b0;
        checks++; if (rsp_vld !== 4'b0100 || rsp_dat !== 8'h42) begin
            errors++; $display("FAIL busy_resp got vld=%b dat=%h exp 0100/42", rsp_vld, rsp_dat);
        end
        $display("txn busy: req2 granted after flash_busy dropped");
        tick();
    endtask

    task automatic test_timeout;
        req_vld = 4'b0010;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL tmo_accept got %b exp 0010", req_rdy); end
        tick();
        req_vld = '0;
        checks++; if (m_req_vld !== 1'b1) begin errors++; $display("FAIL tmo_handshake m_req_vld got %b exp 1", m_req_vld); end
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k < TMO) begin
                checks++; if (rsp_vld !== 4'h0) begin errors++; $display("FAIL tmo_early[%0d] got %b exp 0", k, rsp_vld); end
            end else begin
                checks++; if (rsp_vld !== 4'b0010 || rsp_err !== 1'b1 || rsp_dat !== 8'h00) begin
                    errors++; $display("FAIL tmo_resp got vld=%b err=%b dat=%h exp 0010/1/00", rsp_vld, rsp_err, rsp_dat);
                end
            end
        end
        tick();
        checks++; if (stray_err !== 1'b0) begin errors++; $display("FAIL stray_before got %b exp 0", stray_err); end
        m_rsp_vld = 1'b1;
        m_rsp_dat = 8'h77;
        tick();
        m_rsp_vld = 1'b0;
        checks++; if (stray_err !== 1'b1) begin errors++; $display("FAIL stray_after got %b exp 1", stray_err); end
        $display("txn timeout: req1 timed out after %0d cycles, stray beat dropped", TMO);
    endtask

    task automatic test_stall;
        req_addr[7:4] = 4'hA;
        req_read[1]   = 1'b0;
        req_dat[15:8] = 8'h5C;
        m_req_rdy     = 1'b0;
        req_vld       = 4'b0010;
        #1;
        checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL stall_accept got %b exp 0010", req_rdy); end
        tick();
        req_vld = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_req_vld !== 1'b1 || m_req_addr !== 4'hA || m_req_dat !== 8'h5C || m_req_read !== 1'b0 ||
                          grant !== 4'b0010 || req_rdy !== 4'h0) begin
                errors++; $display("FAIL stall_issue[%0d] got vld=%b addr=%h dat=%h rd=%b g=%b rdy=%b exp 1/a/5c/0/0010/0000",
                                   i, m_req_vld, m_req_addr, m_req_dat, m_req_read, grant, req_rdy);
            end
            tick();
        end
        m_req_rdy = 1'b1;
        #1;
        checks++; if (m_req_vld !== 1'b1 || m_req_dat !== 8'h5C) begin
            errors++; $display("FAIL stall_release got vld=%b dat=%h exp 1/5c", m_req_vld, m_req_dat);
        end
        tick();
        m_rsp_vld = 1'b1;
        m_rsp_dat = 8'h3C;
        rsp_rdy   = 4'b1101;
        tick();
        m_rsp_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_vld !== 4'b0010 || rsp_dat !== 8'h3C || grant !== 4'b0010) begin
                errors++; $display("FAIL stall_resp[%0d] got vld=%b dat=%h g=%b exp 0010/3c/0010", i, rsp_vld, rsp_dat, grant);
            end
            tick();
        end
        req_vld = '0;
        rsp_rdy = 4'hF;
        #1;
        checks++; if (rsp_vld !== 4'b0010) begin errors++; $display("FAIL stall_resp_hold got %b exp 0010", rsp_vld); end
        tick();
        checks++; if (rsp_vld !== 4'h0 || grant !== 4'h0) begin
            errors++; $display("FAIL stall_done got vld=%b g=%b exp 0/0", rsp_vld, grant);
        end
        $display("txn stall: req1 write addr=a dat=5c rsp=3c");
    endtask

    task automatic test_reset_mid;
        req_vld = 4'b1000;
        #1;
        checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL mid_accept got %b exp 1000", req_rdy); end
        tick();
        req_vld = '0;
        tick();
        checks++; if (m_rsp_rdy !== 1'b1 || grant !== 4'b1000) begin
            errors++; $display("FAIL mid_wait got m_rsp_rdy=%b g=%b exp 1/1000", m_rsp_rdy, grant);
        end
        rst = 1'b1;
        #1;
        checks++; if (grant !== 4'h0 || m_req_vld !== 1'b0 || rsp_vld !== 4'h0 || req_rdy !== 4'h0) begin
            errors++; $display("FAIL mid_rst_ctrl got g=%b mvld=%b rvld=%b rdy=%b exp all 0", grant, m_req_vld, rsp_vld, req_rdy);
        end
        checks++; if ({m_req_addr, m_req_dat, rsp_dat, rsp_err, stray_err} !== 22'h0) begin
            errors++; $display("FAIL mid_rst_data got addr=%h dat=%h rdat=%h err=%b stray=%b exp all 0",
                               m_req_addr, m_req_dat, rsp_dat, rsp_err, stray_err);
        end
        tick();
        rst       = 1'b0;
        m_rsp_vld = 1'b1;
        req_vld   = 4'hF;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL mid_next_accept got %b exp 0001", req_rdy); end
        tick();
        m_rsp_vld = 1'b0;
        req_vld   = '0;
        checks++; if (grant !== 4'b0001 || stray_err !== 1'b1) begin
            errors++; $display("FAIL mid_after got g=%b stray=%b exp 0001/1", grant, stray_err);
        end
        $display("txn reset_mid: req3 aborted, req0 granted next");
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_round_robin();
        test_flash_busy();
        test_timeout();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
